// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage sitting directly in front of instructionMemory. It owns the
// program counter, drives the memory address, captures the combinational
// instruction word into a two-entry fetch queue and hands {pc, instr} to
// decode over a valid/ready handshake. A taken branch or jump (redirect)
// flushes the queue and restarts fetch at the word-aligned target.
//
// Ports
//   clk             in   1      system clock, rising edge
//   rst_n           in   1      asynchronous active-low reset
//   imem_addr       out  WIDTH  byte address to instructionMemory (= pc_q)
//   imem_instr      in   WIDTH  instruction read combinationally at imem_addr
//   redirect_valid  in   1      branch/jump taken this cycle
//   redirect_pc     in   WIDTH  redirect target byte address
//   fetch_valid     out  1      queue head holds a valid instruction
//   fetch_ready     in   1      decode accepts the head this cycle
//   fetch_instr     out  WIDTH  head instruction
//   fetch_pc        out  WIDTH  head PC
//   fetch_pc_plus4  out  WIDTH  fetch_pc + 4 (wraps)
//   misalign_err    out  1      one-cycle pulse: last redirect_pc[1:0] != 0
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               QDEPTH   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_instr,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             fetch_valid,
    input  logic             fetch_ready,
    output logic [WIDTH-1:0] fetch_instr,
    output logic [WIDTH-1:0] fetch_pc,
    output logic [WIDTH-1:0] fetch_pc_plus4,
    output logic             misalign_err
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] head_pc_q, head_pc_d;
    logic [WIDTH-1:0] head_instr_q, head_instr_d;
    logic [WIDTH-1:0] tail_pc_q, tail_pc_d;
    logic [WIDTH-1:0] tail_instr_q, tail_instr_d;
    logic             misalign_q, misalign_d;

    logic             pop;
    logic             push_ok;
    logic [1:0]       count_after_pop;

    // The queue is kept as an explicit head/tail pair: a pop shifts the tail
    // into the head, and a push then lands in whichever slot is the first
    // free one after that shift. This keeps the head a plain register so the
    // fetch_* outputs come straight from flops.
    always_comb begin
        pc_d            = pc_q;
        count_d         = count_q;
        head_pc_d       = head_pc_q;
        head_instr_d    = head_instr_q;
        tail_pc_d       = tail_pc_q;
        tail_instr_d    = tail_instr_q;
        misalign_d      = 1'b0;
        count_after_pop = count_q;

        pop     = (count_q != 2'd0) && fetch_ready;
        push_ok = (count_q < 2'(QDEPTH)) || pop;

        if (pop) begin
            head_pc_d       = tail_pc_q;
            head_instr_d    = tail_instr_q;
            count_after_pop = count_q - 2'd1;
        end

        if (redirect_valid) begin
            // Redirect beats everything: any popped entry still counts as
            // consumed, the rest is dropped and nothing is enqueued.
            count_d    = 2'd0;
            pc_d       = {redirect_pc[WIDTH-1:2], 2'b00};
            misalign_d = (redirect_pc[1:0] != 2'b00);
        end else if (push_ok) begin
            if (count_after_pop == 2'd0) begin
                head_pc_d    = pc_q;
                head_instr_d = imem_instr;
            end else begin
                tail_pc_d    = pc_q;
                tail_instr_d = imem_instr;
            end
            count_d = count_after_pop + 2'd1;
            pc_d    = pc_q + WIDTH'(4);
        end
    end

    // Every flop is reset so no output can show X after reset, whatever the
    // memory returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            count_q      <= 2'd0;
            head_pc_q    <= '0;
            head_instr_q <= '0;
            tail_pc_q    <= '0;
            tail_instr_q <= '0;
            misalign_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            count_q      <= count_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            tail_pc_q    <= tail_pc_d;
            tail_instr_q <= tail_instr_d;
            misalign_q   <= misalign_d;
        end
    end

    assign imem_addr      = pc_q;
    assign fetch_valid    = (count_q != 2'd0);
    assign fetch_pc       = head_pc_q;
    assign fetch_instr    = head_instr_q;
    assign fetch_pc_plus4 = head_pc_q + WIDTH'(4);
    assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit. A behavioural model of the fetch stage pushes
// each expected {pc, instr} into a scoreboard queue when the cycle's stimulus
// is driven; the queue head is compared against the DUT outputs every cycle.
// A second instance with RESET_PC near the top of memory covers PC wrap.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_plus4;
    logic        misalign_err;

    logic        rst2_n;
    logic [31:0] imem_addr2;
    logic [31:0] imem_instr2;
    logic        fetch_valid2;
    logic [31:0] fetch_instr2;
    logic [31:0] fetch_pc2;
    logic [31:0] fetch_pc_plus4_2;
    logic        misalign_err2;

    int checkCount;
    int passCount;

    entry_t      sbQueue[$];
    logic [31:0] modelPc;
    logic        modelMis;

    // Instruction memory contents: a few fixed words, a hash elsewhere.
    function automatic logic [31:0] memModel(input logic [31:0] a);
        case (a)
            32'h0000_0000: memModel = 32'h0000_2083;
            32'h0000_0004: memModel = 32'h0040_2103;
            32'h0000_0008: memModel = 32'h0000_01B3;
            32'h0000_000C: memModel = 32'h0000_8863;
            32'h0000_001C: memModel = 32'h0030_2423;
            default:       memModel = a ^ 32'h1357_9BDF;
        endcase
    endfunction

    assign imem_instr  = memModel(imem_addr);
    assign imem_instr2 = memModel(imem_addr2);

    instr_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0), .QDEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
        .fetch_pc_plus4(fetch_pc_plus4), .misalign_err(misalign_err)
    );

    instr_fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) dutWrap (
        .clk(clk), .rst_n(rst2_n), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .fetch_valid(fetch_valid2), .fetch_ready(1'b1),
        .fetch_instr(fetch_instr2), .fetch_pc(fetch_pc2),
        .fetch_pc_plus4(fetch_pc_plus4_2), .misalign_err(misalign_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checkCount++;
        if (got !== exp)
            $display("[TB] FAIL %s: got %08h, expected %08h", tag, got, exp);
        else
            passCount++;
    endtask

    // Compare DUT outputs with the model, then advance the model across the
    // coming rising edge using the stimulus just driven.
    task automatic applyStimulus(input logic ready, input logic redir,
                                 input logic [31:0] rpc);
        int  sizeBefore;
        logic doPop;
        fetch_ready    = ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        checkOutput("imem_addr", imem_addr, modelPc);
        checkOutput("misalign_err", {31'b0, misalign_err}, {31'b0, modelMis});
        checkOutput("fetch_valid", {31'b0, fetch_valid}, {31'b0, sbQueue.size() != 0});
        if (sbQueue.size() != 0) begin
            checkOutput("fetch_pc", fetch_pc, sbQueue[0].pc);
            checkOutput("fetch_instr", fetch_instr, sbQueue[0].instr);
            checkOutput("fetch_pc_plus4", fetch_pc_plus4, sbQueue[0].pc + 32'd4);
        end
        sizeBefore = sbQueue.size();
        doPop = (sizeBefore != 0) && ready;
        if (doPop) void'(sbQueue.pop_front());
        if (redir) begin
            sbQueue.delete();
            modelPc  = {rpc[31:2], 2'b00};
            modelMis = (rpc[1:0] != 2'b00);
        end else begin
            modelMis = 1'b0;
            if (sizeBefore < 2 || doPop) begin
                sbQueue.push_back('{pc: modelPc, instr: memModel(modelPc)});
                modelPc = modelPc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        checkCount     = 0;
        passCount      = 0;
        modelPc        = 32'h0;
        modelMis       = 1'b0;
        rst_n          = 1'b0;
        rst2_n         = 1'b0;
        fetch_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        repeat (2) @(negedge clk);
        checkOutput("reset fetch_valid", {31'b0, fetch_valid}, 32'h0);
        checkOutput("reset fetch_pc", fetch_pc, 32'h0);
        checkOutput("reset fetch_instr", fetch_instr, 32'h0);
        checkOutput("reset fetch_pc_plus4", fetch_pc_plus4, 32'h4);
        checkOutput("reset misalign_err", {31'b0, misalign_err}, 32'h0);
        checkOutput("reset imem_addr", imem_addr, 32'h0);
        rst_n = 1'b1;

        $display("[TB] streaming with fetch_ready=1");
        repeat (4) applyStimulus(1'b1, 1'b0, 32'h0);

        $display("[TB] stall and release");
        rst_n = 1'b0;
        #1;
        sbQueue.delete();
        modelPc = 32'h0;
        modelMis = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("stall imem_addr", imem_addr, 32'h8);
        checkOutput("stall head pc", fetch_pc, 32'h0);
        repeat (4) applyStimulus(1'b1, 1'b0, 32'h0);

        $display("[TB] redirect to 12 with queued entries");
        repeat (2) applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0000_000C);
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);

        $display("[TB] misaligned redirect to 0x1E");
        applyStimulus(1'b1, 1'b1, 32'h0000_001E);
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);

        $display("[TB] back-to-back redirects");
        applyStimulus(1'b1, 1'b1, 32'h0000_0040);
        applyStimulus(1'b0, 1'b1, 32'h0000_0083);
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);

        $display("[TB] random traffic");
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                          32'($urandom_range(0, 255)));
        end

        $display("[TB] reset mid-stall");
        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset fetch_valid", {31'b0, fetch_valid}, 32'h0);
        checkOutput("async reset fetch_pc", fetch_pc, 32'h0);
        checkOutput("async reset fetch_instr", fetch_instr, 32'h0);
        checkOutput("async reset fetch_pc_plus4", fetch_pc_plus4, 32'h4);
        checkOutput("async reset imem_addr", imem_addr, 32'h0);
        sbQueue.delete();
        modelPc  = 32'h0;
        modelMis = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) applyStimulus(1'b1, 1'b0, 32'h0);

        $display("[TB] wrap instance");
        rst2_n = 1'b1;
        @(negedge clk);
        checkOutput("wrap pc0", fetch_pc2, 32'hFFFF_FFF8);
        checkOutput("wrap instr0", fetch_instr2, 32'hFFFF_FFF8 ^ 32'h1357_9BDF);
        @(negedge clk);
        checkOutput("wrap pc1", fetch_pc2, 32'hFFFF_FFFC);
        checkOutput("wrap pc_plus4 at top", fetch_pc_plus4_2, 32'h0);
        @(negedge clk);
        checkOutput("wrap pc2", fetch_pc2, 32'h0);
        checkOutput("wrap instr2", fetch_instr2, 32'h0000_2083);
        checkOutput("wrap valid", {31'b0, fetch_valid2}, 32'h1);
        checkOutput("wrap misalign", {31'b0, misalign_err2}, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
